// File: rtl/mlp_layer_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mlp_layer_seq_if
// Brief    : Input stream, weight-memory read port and output stream of one
//            mlp_layer_seq instance.
// Revision : 1.0 - initial release
// ============================================================================
interface mlp_layer_seq_if #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 200,
    parameter int DW    = 16
);
    localparam int c_aw = $clog2(N_OUT * (N_IN + 1));

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [c_aw-1:0] w_addr;
    logic [DW-1:0]   w_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;

    modport slave (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_addr, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_addr, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/mlp_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : mlp_layer_seq
// Brief    : Time-multiplexed fully-connected layer with one shared MAC and an
//            external synchronous weight/bias memory. Define MLP_RELU_EN to
//            clamp results at zero (hidden layers).
// Revision : 1.0 - initial release
// ============================================================================
module mlp_layer_seq #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 200,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mlp_layer_seq_if.slave bus
);
    localparam int c_aw   = $clog2(N_OUT * (N_IN + 1));
    localparam int c_iw   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int c_cw   = $clog2(N_IN + 2);
    localparam int c_ow   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int c_accw = 2 * DW + $clog2(N_IN + 1);

    localparam logic [c_aw-1:0]          c_stride  = c_aw'(N_IN + 1);
    localparam logic signed [c_accw-1:0] c_sat_max = {{(c_accw-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_accw-1:0] c_sat_min = {{(c_accw-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DW-1:0]            r_buf [N_IN];
    logic [c_iw-1:0]          r_k;
    logic [c_ow-1:0]          r_o;
    logic [c_cw-1:0]          r_cnt;
    logic                     r_pend;
    logic                     r_pend_bias;
    logic [DW-1:0]            r_x;
    logic signed [c_accw-1:0] r_acc;
    logic [c_aw-1:0]          r_base;
    logic [c_aw-1:0]          r_w_addr;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic [DW-1:0]            r_out_data;

    logic                     w_load_fire;
    logic                     w_last_word;
    logic                     w_issue;
    logic                     w_done;
    logic                     w_last_neuron;
    logic [DW-1:0]            w_buf_rd;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [c_accw-1:0] w_term;
    logic signed [c_accw-1:0] w_acc_nxt;
    logic signed [c_accw-1:0] w_shift;
    logic [DW-1:0]            w_res;

    assign w_load_fire   = (r_state == S_LOAD) && bus.in_valid;
    assign w_last_word   = w_load_fire && (r_k == c_iw'(N_IN - 1));
    assign w_issue       = (r_state == S_COMPUTE) && (r_cnt <= c_cw'(N_IN));
    assign w_done        = r_pend && r_pend_bias;
    assign w_last_neuron = (r_o == c_ow'(N_OUT - 1));
    assign w_buf_rd      = (r_cnt < c_cw'(N_IN)) ? r_buf[r_cnt[c_iw-1:0]] : '0;

    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.w_addr    = r_w_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

    // w_data belongs to the address issued one cycle earlier; r_x/r_pend
    // carry the matching activation and bias flag across that latency.
    always_comb begin
        w_prod    = $signed({{DW{bus.w_data[DW-1]}}, bus.w_data})
                  * $signed({{DW{r_x[DW-1]}}, r_x});
        w_term    = {{(c_accw-2*DW){w_prod[2*DW-1]}}, w_prod};
        if (r_pend_bias) begin
            w_term = $signed({{(c_accw-DW){bus.w_data[DW-1]}}, bus.w_data}) <<< FRAC;
        end
        w_acc_nxt = r_acc + w_term;
        w_shift   = w_acc_nxt >>> FRAC;
        w_res     = w_shift[DW-1:0];
        if (w_shift > c_sat_max) begin
            w_res = {1'b0, {(DW-1){1'b1}}};
        end else if (w_shift < c_sat_min) begin
            w_res = {1'b1, {(DW-1){1'b0}}};
        end
`ifdef MLP_RELU_EN
        if (w_res[DW-1]) begin
            w_res = '0;
        end
`else
        w_res = w_res;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:    if (w_last_word) w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_done)      w_state_nxt = S_EMIT;
            S_EMIT:    if (bus.out_ready) w_state_nxt = w_last_neuron ? S_LOAD : S_COMPUTE;
            default:   w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The activation buffer is pure storage; k restarting at 0 discards it.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_buf[r_k] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k         <= '0;
            r_o         <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_bias <= 1'b0;
            r_x         <= '0;
            r_acc       <= '0;
            r_base      <= '0;
            r_w_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_pend      <= 1'b0;
            r_pend_bias <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_last_word) begin
                        r_k      <= '0;
                        r_o      <= '0;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_base   <= '0;
                        r_w_addr <= '0;
                    end else if (w_load_fire) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (w_issue) begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_pend      <= 1'b1;
                        r_pend_bias <= (r_cnt == c_cw'(N_IN));
                        r_x         <= w_buf_rd;
                        if (r_cnt < c_cw'(N_IN)) begin
                            r_w_addr <= r_w_addr + 1'b1;
                        end
                    end
                    if (r_pend) begin
                        r_acc <= w_acc_nxt;
                    end
                    if (w_done) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res;
                        r_out_last  <= w_last_neuron;
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (w_last_neuron) begin
                            r_o      <= '0;
                            r_base   <= '0;
                            r_w_addr <= '0;
                        end else begin
                            r_o      <= r_o + 1'b1;
                            r_base   <= r_base + c_stride;
                            r_w_addr <= r_base + c_stride;
                            r_cnt    <= '0;
                            r_acc    <= '0;
                        end
                    end
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_layer_seq
// Brief    : Directed table plus randomized vectors for mlp_layer_seq with a
//            synchronous weight memory model and an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_seq;
    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int STEP  = N_IN + 1;
`ifdef MLP_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlp_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

    mlp_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0] mem   [16];
    logic [DW-1:0] x     [N_IN];
    logic [DW-1:0] exp_q [N_OUT];
    int n_vec = 0;
    int n_bad = 0;

    always @(posedge clk) bus.w_data <= mem[bus.w_addr];

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        logic [DW-1:0] b;
        logic [DW-1:0] e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact integer dot product, floor division, clamp.
    function automatic logic [DW-1:0] model(input int o);
        longint acc = 0;
        longint q;
        logic [63:0] r;
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(x[i])) * longint'($signed(mem[o*STEP+i]));
        acc += longint'($signed(mem[o*STEP+N_IN])) * (longint'(1) << FRAC);
        q = acc / (longint'(1) << FRAC);
        if (acc < 0 && (acc % (longint'(1) << FRAC)) != 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        if (RELU && q < 0) q = 0;
        r = q;
        return r[DW-1:0];
    endfunction

    task automatic send_word(input logic [DW-1:0] d);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("load_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vector(input string tag, input int hold, input bit gaps, input bit timed);
        int lat;
        for (int k = 0; k < N_IN; k++) begin
            if (gaps && k > 0) @(negedge clk);
            send_word(x[k]);
        end
        check({tag, "_busy_ready"}, bus.in_ready, 0);
        if (gaps) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hBEEF;
            repeat (2) begin
                @(negedge clk);
                check({tag, "_compute_ready"}, bus.in_ready, 0);
            end
            bus.in_valid = 1'b0;
        end
        for (int o = 0; o < N_OUT; o++) begin
            lat = 0;
            while (bus.out_valid !== 1'b1 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check({tag, "_valid"}, bus.out_valid, 1);
            if (timed) check({tag, "_latency"}, lat, N_IN + 2);
            check({tag, "_data"}, bus.out_data, exp_q[o]);
            check({tag, "_last"}, bus.out_last, (o == N_OUT - 1) ? 1 : 0);
            if (o == 0) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    check({tag, "_hold_valid"}, bus.out_valid, 1);
                    check({tag, "_hold_data"}, bus.out_data, exp_q[0]);
                    check({tag, "_hold_addr"}, bus.w_addr, N_IN);
                end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        check({tag, "_ready_after"}, bus.in_ready, 1);
    endtask

    task automatic randomize_data(input bit wide);
        for (int i = 0; i < 16; i++)
            mem[i] = wide ? DW'($urandom_range(0, 65535)) : DW'($urandom_range(0, 1023) - 512);
        for (int i = 0; i < N_IN; i++)
            x[i] = wide ? DW'($urandom_range(0, 65535)) : DW'($urandom_range(0, 2047) - 1024);
        for (int o = 0; o < N_OUT; o++) exp_q[o] = model(o);
    endtask

    initial begin
        vec_t tbl [5];
        int lat;
        tbl[0] = '{x: 16'h0100, w: 16'h0080, b: 16'h0040, e: 16'h0240};
        tbl[1] = '{x: 16'h7FFF, w: 16'h7FFF, b: 16'h7FFF, e: 16'h7FFF};
        tbl[2] = '{x: 16'h7FFF, w: 16'h8000, b: 16'h0000, e: RELU ? 16'h0000 : 16'h8000};
        tbl[3] = '{x: 16'h0100, w: 16'hFFC0, b: 16'h0000, e: RELU ? 16'h0000 : 16'hFF00};
        tbl[4] = '{x: 16'h0001, w: 16'hFFFF, b: 16'h0000, e: RELU ? 16'h0000 : 16'hFFFF};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_out_last",  bus.out_last, 0);
        check("rst_w_addr",    bus.w_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            for (int o = 0; o < N_OUT; o++) begin
                for (int i = 0; i < N_IN; i++) mem[o*STEP+i] = tbl[t].w;
                mem[o*STEP+N_IN] = tbl[t].b;
                exp_q[o] = tbl[t].e;
            end
            for (int i = 0; i < N_IN; i++) x[i] = tbl[t].x;
            run_vector($sformatf("tbl%0d", t), (t == 0) ? 5 : 0, 1'b0, 1'b1);
        end

        for (int it = 0; it < 8; it++) begin
            randomize_data(it[0]);
            run_vector($sformatf("rnd%0d", it), int'($urandom_range(0, 3)), it == 2, it != 2);
        end

        // Reset while neuron 1 is being computed.
        randomize_data(1'b0);
        for (int k = 0; k < N_IN; k++) send_word(x[k]);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("mid_first_data", bus.out_data, exp_q[0]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_w_addr", bus.w_addr, STEP + 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready",  bus.in_ready, 1);
        check("mid_rst_w_addr",    bus.w_addr, 0);
        check("mid_rst_out_data",  bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        randomize_data(1'b0);
        run_vector("post_rst", 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
